// File: rtl/triangle_setup.sv
// Per-triangle setup: doubled signed area, CCW winding fix, clipped bounding box
// and a Q2.30 inverse area from a 31-step restoring divider. One triangle in flight.
module triangle_setup #(
  parameter int unsigned COORD_W  = 12,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [COORD_W-1:0] i_x0, i_x1, i_x2,
  input  logic [COORD_W-1:0] i_y0, i_y1, i_y2,
  input  logic [7:0]         i_z0, i_z1, i_z2,
  input  logic [31:0]        i_u0, i_u1, i_u2,
  input  logic [31:0]        i_v0, i_v1, i_v2,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [COORD_W-1:0] o_x0, o_x1, o_x2,
  output logic [COORD_W-1:0] o_y0, o_y1, o_y2,
  output logic [7:0]         o_z0, o_z1, o_z2,
  output logic [31:0]        o_u0, o_u1, o_u2,
  output logic [31:0]        o_v0, o_v1, o_v2,
  output logic [31:0]        o_inv_area,
  output logic [15:0]        o_bb_xmin, o_bb_xmax,
  output logic [15:0]        o_bb_ymin, o_bb_ymax,
  output logic               o_culled
);

  localparam int unsigned AW = 2 * COORD_W + 2;
  localparam logic signed [COORD_W-1:0] XLim = COORD_W'(SCREEN_W);
  localparam logic signed [COORD_W-1:0] YLim = COORD_W'(SCREEN_H);
  localparam logic signed [COORD_W-1:0] XHi  = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] YHi  = COORD_W'(SCREEN_H - 1);

  typedef enum logic [2:0] {StIdle, StArea, StCheck, StDiv, StOut} state_e;
  state_e state_q, state_d;

  logic signed [COORD_W-1:0] x_q [3];
  logic signed [COORD_W-1:0] y_q [3];
  logic [7:0]                z_q [3];
  logic [31:0]               u_q [3];
  logic [31:0]               v_q [3];
  logic signed [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic signed [AW-1:0]      prod_a_q, prod_b_q, area2_q;
  logic                      area_phase_q;
  logic [31:0]               divisor_q, quot_q;
  logic [30:0]               rem_q;
  logic [4:0]                cnt_q;
  logic [15:0]               bb_xmin_q, bb_xmax_q, bb_ymin_q, bb_ymax_q;
  logic                      culled_q;

  logic signed [COORD_W:0] dx1, dy1, dx2, dy2;
  logic signed [AW-1:0]    prod_a, prod_b, area_abs;
  logic                    degenerate, offscreen;
  logic [31:0]             rem_shift;
  logic                    rem_ge;

  function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a, b, c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a, b, c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [15:0] clamp(input logic signed [COORD_W-1:0] val,
                                        input logic signed [COORD_W-1:0] hi);
    if (val < 0) return 16'd0;
    if (val > hi) return 16'($unsigned(hi));
    return 16'($unsigned(val));
  endfunction

  always_comb begin
    dx1        = x_q[1] - x_q[0];
    dy1        = y_q[1] - y_q[0];
    dx2        = x_q[2] - x_q[0];
    dy2        = y_q[2] - y_q[0];
    prod_a     = dx1 * dy2;
    prod_b     = dx2 * dy1;
    area_abs   = area2_q[AW-1] ? -area2_q : area2_q;
    degenerate = (area2_q == '0);
    offscreen  = (xmax_q < 0) || (ymax_q < 0) || (xmin_q >= XLim) || (ymin_q >= YLim);
    // Dividend is 2^30: its only set bit enters on the first step.
    rem_shift  = {rem_q, (cnt_q == 5'd30)};
    rem_ge     = (rem_shift >= divisor_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_valid) state_d = StArea;
      StArea:  if (area_phase_q) state_d = StCheck;
      StCheck: state_d = (degenerate || offscreen) ? StIdle : StDiv;
      StDiv:   if (cnt_q == 5'd0) state_d = StOut;
      StOut:   if (i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
        u_q[i] <= '0;
        v_q[i] <= '0;
      end
      {xmin_q, xmax_q, ymin_q, ymax_q}   <= '0;
      {prod_a_q, prod_b_q, area2_q}      <= '0;
      area_phase_q                       <= 1'b0;
      {divisor_q, quot_q, rem_q, cnt_q}  <= '0;
      {bb_xmin_q, bb_xmax_q}             <= '0;
      {bb_ymin_q, bb_ymax_q}             <= '0;
      culled_q                           <= 1'b0;
    end else begin
      culled_q <= 1'b0;
      case (state_q)
        StIdle: if (i_valid) begin
          x_q[0] <= $signed(i_x0); x_q[1] <= $signed(i_x1); x_q[2] <= $signed(i_x2);
          y_q[0] <= $signed(i_y0); y_q[1] <= $signed(i_y1); y_q[2] <= $signed(i_y2);
          z_q[0] <= i_z0; z_q[1] <= i_z1; z_q[2] <= i_z2;
          u_q[0] <= i_u0; u_q[1] <= i_u1; u_q[2] <= i_u2;
          v_q[0] <= i_v0; v_q[1] <= i_v1; v_q[2] <= i_v2;
          area_phase_q <= 1'b0;
        end
        // Two-stage area: products first, subtraction next cycle.
        StArea: begin
          if (!area_phase_q) begin
            prod_a_q     <= prod_a;
            prod_b_q     <= prod_b;
            xmin_q       <= min3(x_q[0], x_q[1], x_q[2]);
            xmax_q       <= max3(x_q[0], x_q[1], x_q[2]);
            ymin_q       <= min3(y_q[0], y_q[1], y_q[2]);
            ymax_q       <= max3(y_q[0], y_q[1], y_q[2]);
            area_phase_q <= 1'b1;
          end else begin
            area2_q <= prod_a_q - prod_b_q;
          end
        end
        StCheck: begin
          if (degenerate || offscreen) begin
            culled_q <= 1'b1;
          end else begin
            if (area2_q[AW-1]) begin
              x_q[1] <= x_q[2]; x_q[2] <= x_q[1];
              y_q[1] <= y_q[2]; y_q[2] <= y_q[1];
              z_q[1] <= z_q[2]; z_q[2] <= z_q[1];
              u_q[1] <= u_q[2]; u_q[2] <= u_q[1];
              v_q[1] <= v_q[2]; v_q[2] <= v_q[1];
            end
            divisor_q <= 32'($unsigned(area_abs));
            bb_xmin_q <= clamp(xmin_q, XHi);
            bb_xmax_q <= clamp(xmax_q, XHi);
            bb_ymin_q <= clamp(ymin_q, YHi);
            bb_ymax_q <= clamp(ymax_q, YHi);
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= 5'd30;
          end
        end
        StDiv: begin
          rem_q  <= rem_ge ? 31'(rem_shift - divisor_q) : rem_shift[30:0];
          quot_q <= {quot_q[30:0], rem_ge};
          cnt_q  <= cnt_q - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = i_rst_n && (state_q == StIdle);
  assign o_valid    = (state_q == StOut);
  assign o_culled   = culled_q;
  assign o_inv_area = quot_q;
  assign o_bb_xmin  = bb_xmin_q;
  assign o_bb_xmax  = bb_xmax_q;
  assign o_bb_ymin  = bb_ymin_q;
  assign o_bb_ymax  = bb_ymax_q;
  assign o_x0 = x_q[0]; assign o_x1 = x_q[1]; assign o_x2 = x_q[2];
  assign o_y0 = y_q[0]; assign o_y1 = y_q[1]; assign o_y2 = y_q[2];
  assign o_z0 = z_q[0]; assign o_z1 = z_q[1]; assign o_z2 = z_q[2];
  assign o_u0 = u_q[0]; assign o_u1 = u_q[1]; assign o_u2 = u_q[2];
  assign o_v0 = v_q[0]; assign o_v1 = v_q[1]; assign o_v2 = v_q[2];

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: latency, winding fix, divider values, culling,
// back-pressure hold and mid-operation reset.
module tb_triangle_setup;

  localparam int CW = 12;

  logic          i_clk, i_rst_n, i_valid, i_ready, o_ready, o_valid, o_culled;
  logic [CW-1:0] i_x0, i_x1, i_x2, i_y0, i_y1, i_y2;
  logic [CW-1:0] o_x0, o_x1, o_x2, o_y0, o_y1, o_y2;
  logic [7:0]    i_z0, i_z1, i_z2, o_z0, o_z1, o_z2;
  logic [31:0]   i_u0, i_u1, i_u2, i_v0, i_v1, i_v2;
  logic [31:0]   o_u0, o_u1, o_u2, o_v0, o_v1, o_v2;
  logic [31:0]   o_inv_area;
  logic [15:0]   o_bb_xmin, o_bb_xmax, o_bb_ymin, o_bb_ymax;

  int n_checks = 0;
  int n_fail   = 0;
  int val_at, cul_at, cul_cnt, bad;
  logic [31:0] snap;

  triangle_setup #(.COORD_W(CW), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_x0(i_x0), .i_x1(i_x1), .i_x2(i_x2), .i_y0(i_y0), .i_y1(i_y1), .i_y2(i_y2),
    .i_z0(i_z0), .i_z1(i_z1), .i_z2(i_z2), .i_u0(i_u0), .i_u1(i_u1), .i_u2(i_u2),
    .i_v0(i_v0), .i_v1(i_v1), .i_v2(i_v2), .o_valid(o_valid), .i_ready(i_ready),
    .o_x0(o_x0), .o_x1(o_x1), .o_x2(o_x2), .o_y0(o_y0), .o_y1(o_y1), .o_y2(o_y2),
    .o_z0(o_z0), .o_z1(o_z1), .o_z2(o_z2), .o_u0(o_u0), .o_u1(o_u1), .o_u2(o_u2),
    .o_v0(o_v0), .o_v1(o_v1), .o_v2(o_v2), .o_inv_area(o_inv_area),
    .o_bb_xmin(o_bb_xmin), .o_bb_xmax(o_bb_xmax), .o_bb_ymin(o_bb_ymin),
    .o_bb_ymax(o_bb_ymax), .o_culled(o_culled)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshake one triangle; z/u/v tag each input vertex by its index.
  task automatic issue(input int ax0, ay0, ax1, ay1, ax2, ay2);
    @(negedge i_clk);
    i_x0 = CW'(ax0); i_y0 = CW'(ay0);
    i_x1 = CW'(ax1); i_y1 = CW'(ay1);
    i_x2 = CW'(ax2); i_y2 = CW'(ay2);
    i_z0 = 8'd10; i_z1 = 8'd20; i_z2 = 8'd30;
    i_u0 = 32'h0001_0000; i_u1 = 32'h0002_0000; i_u2 = 32'h0003_0000;
    i_v0 = 32'h0000_0100; i_v1 = 32'h0000_0200; i_v2 = 32'h0000_0300;
    check_eq("ready_before_issue", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  // Cycle number (after the handshake edge) of first o_valid / o_culled, -1 if none.
  task automatic wait_result();
    val_at = -1; cul_at = -1; cul_cnt = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge i_clk);
      #1;
      if (o_culled) begin
        cul_cnt++;
        if (cul_at < 0) cul_at = n;
      end
      if (o_valid) begin
        val_at = n;
        break;
      end
    end
  endtask

  task automatic accept();
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    check_eq("valid_drop_after_accept", {31'd0, o_valid}, 32'd0);
    check_eq("ready_after_accept", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    {i_x0, i_x1, i_x2, i_y0, i_y1, i_y2} = '0;
    {i_z0, i_z1, i_z2} = '0;
    {i_u0, i_u1, i_u2, i_v0, i_v1, i_v2} = '0;

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_ready", {31'd0, o_ready}, 32'd0);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_culled", {31'd0, o_culled}, 32'd0);
    check_eq("rst_inv_area", o_inv_area, 32'd0);
    check_eq("rst_bb_xmax", {16'd0, o_bb_xmax}, 32'd0);
    check_eq("rst_x1", {20'd0, o_x1}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 check_eq("ready_after_rst", {31'd0, o_ready}, 32'd1);

    // 1: area2 = 16, CCW
    issue(0, 0, 4, 0, 0, 4);
    wait_result();
    check_eq("t1_latency", 32'(val_at), 32'd34);
    check_eq("t1_no_cull", 32'(cul_cnt), 32'd0);
    check_eq("t1_inv_area", o_inv_area, 32'h0400_0000);
    check_eq("t1_ready_low", {31'd0, o_ready}, 32'd0);
    check_eq("t1_bb", {o_bb_xmin[7:0], o_bb_xmax[7:0], o_bb_ymin[7:0], o_bb_ymax[7:0]},
             32'h0004_0004);
    check_eq("t1_v1", {o_x1[7:0], o_y1[7:0], o_z1, o_u1[23:16]}, 32'h0400_1402);
    check_eq("t1_v2", {o_x2[7:0], o_y2[7:0], o_z2, o_u2[23:16]}, 32'h0004_1e03);
    accept();

    // 2: same triangle, CW order: swap restores vertex 1/2
    issue(0, 0, 0, 4, 4, 0);
    wait_result();
    check_eq("t2_latency", 32'(val_at), 32'd34);
    check_eq("t2_inv_area", o_inv_area, 32'h0400_0000);
    check_eq("t2_bb", {o_bb_xmin[7:0], o_bb_xmax[7:0], o_bb_ymin[7:0], o_bb_ymax[7:0]},
             32'h0004_0004);
    check_eq("t2_v0", {o_x0[7:0], o_y0[7:0], o_z0, o_u0[23:16]}, 32'h0000_0a01);
    check_eq("t2_v1", {o_x1[7:0], o_y1[7:0], o_z1, o_u1[23:16]}, 32'h0400_1e03);
    check_eq("t2_v2", {o_x2[7:0], o_y2[7:0], o_z2, o_u2[23:16]}, 32'h0004_1402);
    check_eq("t2_v1_v", o_v1, 32'h0000_0300);
    accept();

    // 3: unit area and a non-power-of-two area
    issue(0, 0, 1, 0, 0, 1);
    wait_result();
    check_eq("t3a_inv_area", o_inv_area, 32'h4000_0000);
    accept();
    issue(0, 0, 3, 0, 0, 1);
    wait_result();
    check_eq("t3b_inv_area", o_inv_area, 32'h1555_5555);
    accept();

    // 4: degenerate and off-screen culls
    issue(0, 0, 2, 2, 4, 4);
    wait_result();
    check_eq("t4a_cull_at", 32'(cul_at), 32'd3);
    check_eq("t4a_cull_width", 32'(cul_cnt), 32'd1);
    check_eq("t4a_no_valid", 32'(val_at), 32'hffff_ffff);
    issue(400, 0, 410, 0, 400, 10);
    wait_result();
    check_eq("t4b_cull_at", 32'(cul_at), 32'd3);
    check_eq("t4b_no_valid", 32'(val_at), 32'hffff_ffff);

    // 5: clipping and back-pressure; i_valid during OUT must be ignored
    issue(-10, -10, 500, 0, 0, 300);
    wait_result();
    check_eq("t5_latency", 32'(val_at), 32'd34);
    check_eq("t5_bb_x", {o_bb_xmin, o_bb_xmax}, {16'd0, 16'd319});
    check_eq("t5_bb_y", {o_bb_ymin, o_bb_ymax}, {16'd0, 16'd239});
    check_eq("t5_inv_area", o_inv_area, 32'd6795);
    snap = o_inv_area;
    bad = 0;
    i_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge i_clk);
      #1;
      if (!o_valid || o_ready || o_inv_area != snap || o_bb_xmax != 16'd319 ||
          o_x1 != CW'(500)) bad++;
    end
    i_valid = 1'b0;
    check_eq("t5_hold_bad_cycles", 32'(bad), 32'd0);
    accept();

    // 6: reset during DIV aborts the triangle
    issue(0, 0, 4, 0, 0, 4);
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check_eq("t6_valid_in_rst", {31'd0, o_valid}, 32'd0);
    check_eq("t6_ready_in_rst", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 check_eq("t6_ready_after_rst", {31'd0, o_ready}, 32'd1);
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge i_clk);
      #1;
      if (o_valid || o_culled || !o_ready) bad++;
    end
    check_eq("t6_aborted_quiet", 32'(bad), 32'd0);
    issue(0, 0, 3, 0, 0, 1);
    wait_result();
    check_eq("t6_new_latency", 32'(val_at), 32'd34);
    check_eq("t6_new_inv_area", o_inv_area, 32'h1555_5555);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
